// File: rtl/func_unit_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one shared function unit.
// Optional WAIT-state watchdog enabled by defining FU_ARB_TIMEOUT_EN.
module func_unit_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         ack,
    output logic [31:0]                rsp_result,
    output logic                       rsp_error,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       fu_start,
    input  logic                       fu_done,
    input  logic [31:0]                fu_result
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned DW  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("func_unit_arbiter: NUM_REQ out of range 2..16");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("func_unit_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    state_e               state_q, state_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DW-1:0]        rsp_result_q, rsp_result_d;
    logic                 fu_start_q, fu_start_d;
    logic                 busy_q, busy_d;
    logic                 pick_valid;
    logic [IDW-1:0]       pick_id;
    logic [IDW-1:0]       pick_idx;

`ifdef FU_ARB_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES);
    logic [WDW-1:0]       wdog_q, wdog_d;
    logic                 rsp_error_q, rsp_error_d;
`endif

    // Round-robin pick: descending scan so the smallest offset from last_grant wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        pick_idx   = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            pick_idx = IDW'((32'(last_grant_q) + k) % NUM_REQ);
            if (req[pick_idx]) begin
                pick_valid = 1'b1;
                pick_id    = pick_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        ack_d        = '0;
        rsp_result_d = rsp_result_q;
`ifdef FU_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        rsp_error_d  = rsp_error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_id_d = pick_id;
                    state_d    = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef FU_ARB_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            WAIT: begin
                // A completion in the expiry cycle still returns a normal result.
                if (fu_done) begin
                    rsp_result_d      = fu_result;
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = RESP;
`ifdef FU_ARB_TIMEOUT_EN
                    rsp_error_d       = 1'b0;
                end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_result_d      = '0;
                    rsp_error_d       = 1'b1;
                    ack_d[grant_id_q] = 1'b1;
                    state_d           = RESP;
                end else begin
                    wdog_d            = wdog_q + WDW'(1);
`endif
                end
            end
            RESP: begin
                last_grant_d = grant_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        fu_start_d = (state_d == START);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            ack_q        <= '0;
            rsp_result_q <= '0;
            fu_start_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            rsp_result_q <= rsp_result_d;
            fu_start_q   <= fu_start_d;
            busy_q       <= busy_d;
        end
    end

`ifdef FU_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q      <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            wdog_q      <= wdog_d;
            rsp_error_q <= rsp_error_d;
        end
    end
    assign rsp_error = rsp_error_q;
`else
    assign rsp_error = 1'b0;
`endif

    assign ack        = ack_q;
    assign rsp_result = rsp_result_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign fu_start   = fu_start_q;

endmodule

// File: tb/tb_func_unit_arbiter.sv
// Directed self-checking bench for func_unit_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_func_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [3:0]  ack;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic [1:0]  grant_id;
    logic        busy;
    logic        fu_start;
    logic        fu_done = 1'b0;
    logic [31:0] fu_result = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    bit          t_got;
    logic [1:0]  t_gid;
    logic [3:0]  t_ack;
    logic [31:0] t_res;
    logic        t_err;
    int          t_starts;
    int          t_lat;

    func_unit_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .grant_id(grant_id),
        .busy(busy), .fu_start(fu_start), .fu_done(fu_done), .fu_result(fu_result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; fu_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one transaction from a negedge; fu_done lands d cycles after fu_start.
    task automatic run_txn(input logic [3:0] r, input bit hold, input int d, input logic [31:0] res);
        t_got = 1'b0; t_gid = 'x; t_ack = 'x; t_res = 'x; t_err = 1'bx; t_starts = 0; t_lat = 0;
        req = r;
        for (int i = 0; i < 20 && !t_got; i++) begin
            @(negedge clk);
            t_lat++;
            if (fu_start) t_got = 1'b1;
        end
        if (!t_got) begin
            req = '0;
            return;
        end
        t_gid = grant_id;
        t_starts = 1;
        if (!hold) req = '0;
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (fu_start) t_starts++;
        end
        fu_done = 1'b1; fu_result = res;
        @(negedge clk);
        fu_done = 1'b0;
        if (fu_start) t_starts++;
        t_ack = ack; t_res = rsp_result; t_err = rsp_error;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_tests++; if (ack !== 4'b0)        begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
        n_tests++; if (fu_start !== 1'b0)   begin n_fail++; $display("FAIL reset_fu_start got=%b exp=0", fu_start); end
        n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", rsp_result); end
        n_tests++; if (rsp_error !== 1'b0)  begin n_fail++; $display("FAIL reset_error got=%b exp=0", rsp_error); end
        n_tests++; if (grant_id !== 2'd0)   begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    endtask

    task automatic test_single();
        run_txn(4'b0001, 1'b0, 3, 32'hDEADBEEF);
        n_tests++; if (t_got !== 1'b1)       begin n_fail++; $display("FAIL single_start_seen got=%b exp=1", t_got); end
        n_tests++; if (t_lat !== 1)          begin n_fail++; $display("FAIL single_start_latency got=%0d exp=1", t_lat); end
        n_tests++; if (t_gid !== 2'd0)       begin n_fail++; $display("FAIL single_grant got=%0d exp=0", t_gid); end
        n_tests++; if (t_starts !== 1)       begin n_fail++; $display("FAIL single_start_pulses got=%0d exp=1", t_starts); end
        n_tests++; if (t_ack !== 4'b0001)    begin n_fail++; $display("FAIL single_ack got=%b exp=0001", t_ack); end
        n_tests++; if (t_res !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_result got=%h exp=deadbeef", t_res); end
        n_tests++; if (t_err !== 1'b0)       begin n_fail++; $display("FAIL single_error got=%b exp=0", t_err); end
        @(negedge clk);
        n_tests++; if (ack !== 4'b0)         begin n_fail++; $display("FAIL single_ack_pulse got=%b exp=0000", ack); end
        n_tests++; if (rsp_result !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_result_hold got=%h exp=deadbeef", rsp_result); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ack;
        logic [1:0]  sparse_exp [3];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(4'b1111, 1'b1, 1 + (i % 3), 32'h1000 + 32'(i));
            exp_ack = 4'b0001 << (i % 4);
            n_tests++; if (t_gid !== 2'(i % 4)) begin n_fail++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, t_gid, i % 4); end
            n_tests++; if (t_ack !== exp_ack)   begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp=%b", i, t_ack, exp_ack); end
            n_tests++; if (t_res !== 32'h1000 + 32'(i)) begin n_fail++; $display("FAIL rr_result[%0d] got=%h exp=%h", i, t_res, 32'h1000 + 32'(i)); end
        end
        sparse_exp = '{2'd1, 2'd3, 2'd1};
        for (int i = 0; i < 3; i++) begin
            run_txn(4'b1010, 1'b1, 2, 32'h2000 + 32'(i));
            n_tests++; if (t_gid !== sparse_exp[i]) begin n_fail++; $display("FAIL rr_sparse_grant[%0d] got=%0d exp=%0d", i, t_gid, sparse_exp[i]); end
        end
        req = '0;
    endtask

    task automatic test_drop();
        run_txn(4'b0100, 1'b0, 5, 32'h0000_0D07);
        n_tests++; if (t_ack !== 4'b0100)      begin n_fail++; $display("FAIL drop_ack got=%b exp=0100", t_ack); end
        n_tests++; if (t_res !== 32'h0000_0D07) begin n_fail++; $display("FAIL drop_result got=%h exp=00000d07", t_res); end
    endtask

    task automatic test_back_to_back();
        run_txn(4'b0001, 1'b1, 2, 32'hB2B0_0001);
        n_tests++; if (t_ack !== 4'b0001) begin n_fail++; $display("FAIL b2b_ack0 got=%b exp=0001", t_ack); end
        run_txn(4'b0001, 1'b0, 1, 32'hB2B0_0002);
        n_tests++; if (t_lat !== 2)       begin n_fail++; $display("FAIL b2b_gap got=%0d exp=2", t_lat); end
        n_tests++; if (t_ack !== 4'b0001) begin n_fail++; $display("FAIL b2b_ack1 got=%b exp=0001", t_ack); end
        n_tests++; if (t_res !== 32'hB2B0_0002) begin n_fail++; $display("FAIL b2b_result got=%h exp=b2b00002", t_res); end
    endtask

    task automatic test_idle_done();
        repeat (2) @(negedge clk);
        fu_done = 1'b1; fu_result = 32'h1234_5678;
        @(negedge clk);
        fu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ack !== 4'b0 || busy !== 1'b0 || fu_start !== 1'b0 || rsp_result !== 32'hB2B0_0002) begin
                n_fail++;
                $display("FAIL idle_done[%0d] ack=%b busy=%b start=%b result=%h exp 0000/0/0/b2b00002",
                         i, ack, busy, fu_start, rsp_result);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fu_start) seen = 1'b1;
        end
        req = '0;
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rstmid_start got=0 exp=1"); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || ack !== 4'b0) begin n_fail++; $display("FAIL rstmid_async busy=%b ack=%b exp 0/0000", busy, ack); end
        @(negedge clk);
        rst_n = 1'b1;
        fu_done = 1'b1; fu_result = 32'hAAAA_AAAA;
        @(negedge clk);
        fu_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ack !== 4'b0 || fu_start !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_late_done[%0d] ack=%b start=%b busy=%b exp 0000/0/0", i, ack, fu_start, busy);
            end
            @(negedge clk);
        end
        run_txn(4'b0110, 1'b0, 2, 32'h0000_0110);
        n_tests++; if (t_gid !== 2'd1)    begin n_fail++; $display("FAIL rstmid_regrant got=%0d exp=1", t_gid); end
        n_tests++; if (t_ack !== 4'b0010) begin n_fail++; $display("FAIL rstmid_ack got=%b exp=0010", t_ack); end
    endtask

`ifdef FU_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit seen = 1'b0;
        int cnt = 0;
        req = 4'b0001;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (fu_start) seen = 1'b1;
        end
        req = '0;
        n_tests++; if (!seen) begin n_fail++; $display("FAIL tmo_start got=0 exp=1"); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            cnt++;
            if (ack !== 4'b0) seen = 1'b1;
        end
        n_tests++; if (!seen)      begin n_fail++; $display("FAIL tmo_ack_seen got=0 exp=1"); end
        n_tests++; if (cnt !== 17) begin n_fail++; $display("FAIL tmo_latency got=%0d exp=17", cnt); end
        n_tests++; if (ack !== 4'b0001 || rsp_result !== 32'h0 || rsp_error !== 1'b1) begin
            n_fail++; $display("FAIL tmo_resp ack=%b result=%h err=%b exp 0001/0/1", ack, rsp_result, rsp_error);
        end
        run_txn(4'b0010, 1'b0, 2, 32'hC0FF_EE01);
        n_tests++; if (t_ack !== 4'b0010 || t_res !== 32'hC0FF_EE01 || t_err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_next ack=%b result=%h err=%b exp 0010/c0ffee01/0", t_ack, t_res, t_err);
        end
        run_txn(4'b0001, 1'b0, 16, 32'hFACE_0016);
        n_tests++; if (t_ack !== 4'b0001 || t_res !== 32'hFACE_0016 || t_err !== 1'b0) begin
            n_fail++; $display("FAIL tmo_tie ack=%b result=%h err=%b exp 0001/face0016/0", t_ack, t_res, t_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        run_txn(4'b0001, 1'b0, 40, 32'h5107_0040);
        n_tests++; if (t_ack !== 4'b0001 || t_res !== 32'h5107_0040 || t_err !== 1'b0) begin
            n_fail++; $display("FAIL long_wait ack=%b result=%h err=%b exp 0001/51070040/0", t_ack, t_res, t_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_back_to_back();
        test_idle_done();
        test_reset_mid();
`ifdef FU_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
